// File: rtl/logic_gates_checker.sv
// Self-checking consumer for logic_gates: compares sampled outputs against golden values and keeps run statistics.
// Updates are visible one cycle after acceptance; there is no backpressure, so every valid vector in RUN is consumed.
module logic_gates_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and_out,
  input  logic             or_out,
  input  logic             not_out,
  input  logic             nand_out,
  input  logic             nor_out,
  input  logic             xor_out,
  input  logic             xnor_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_fail_vec,
  output logic [1:0]       first_fail_ab,
  output logic [6:0]       first_fail_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] ffv_q, ffv_d;
  logic [1:0]       ffab_q, ffab_d;
  logic [6:0]       ffm_q, ffm_d;
  logic             pass_q, pass_d;

  logic [6:0] golden;
  logic [6:0] actual;
  logic [6:0] mask;
  logic       accept;
  logic       restart;

  assign golden  = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign actual  = {xnor_out, xor_out, nor_out, nand_out, not_out, or_out, and_out};
  assign mask    = golden ^ actual;
  assign accept  = (state_q == RUN) && in_valid;
  // Clearing on start takes priority over a coincident vector outside RUN.
  assign restart = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    seen_d  = seen_q;
    ffv_d   = ffv_q;
    ffab_d  = ffab_q;
    ffm_d   = ffm_q;
    pass_d  = pass_q;
    if (restart) begin
      state_d = RUN;
      vec_d   = '0;
      err_d   = '0;
      cov_d   = '0;
      seen_d  = 1'b0;
      ffv_d   = '0;
      ffab_d  = '0;
      ffm_d   = '0;
      pass_d  = 1'b0;
    end else if (accept) begin
      vec_d = vec_q + 1'b1;
      cov_d = cov_q | (4'b0001 << {a, b});
      if (mask != 7'd0) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        if (!seen_q) begin
          seen_d = 1'b1;
          ffv_d  = vec_q;
          ffab_d = {a, b};
          ffm_d  = mask;
        end
      end
      if (vec_d == CNT_W'(NUM_VEC)) begin
        state_d = DONE;
        pass_d  = (err_d == '0) && (cov_d == 4'hF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      seen_q  <= 1'b0;
      ffv_q   <= '0;
      ffab_q  <= '0;
      ffm_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      seen_q  <= seen_d;
      ffv_q   <= ffv_d;
      ffab_q  <= ffab_d;
      ffm_q   <= ffm_d;
      pass_q  <= pass_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign vec_count       = vec_q;
  assign err_count       = err_q;
  assign cov             = cov_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_ab   = ffab_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Bench for logic_gates_checker: table of runs with expected final statistics, plus reset and restart sequences.
module tb_logic_gates_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0;
  logic       and_out = 1'b0, or_out = 1'b0, not_out = 1'b0, nand_out = 1'b0;
  logic       nor_out = 1'b0, xor_out = 1'b0, xnor_out = 1'b0;
  logic       busy, done, pass;
  logic [7:0] vec_count, err_count, first_fail_vec;
  logic [3:0] cov;
  logic [1:0] first_fail_ab;
  logic [6:0] first_fail_mask;

  logic_gates_checker #(.NUM_VEC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .and_out(and_out), .or_out(or_out), .not_out(not_out), .nand_out(nand_out),
    .nor_out(nor_out), .xor_out(xor_out), .xnor_out(xnor_out),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .cov(cov), .first_fail_vec(first_fail_vec), .first_fail_ab(first_fail_ab),
    .first_fail_mask(first_fail_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][1:0] ab;
    logic [3:0][6:0] flt;
    logic            gap;
    logic [7:0]      exp_err;
    logic [3:0]      exp_cov;
    logic            exp_pass;
    logic [7:0]      exp_ffv;
    logic [1:0]      exp_ffab;
    logic [6:0]      exp_ffm;
  } run_t;

  typedef struct packed {
    logic [7:0] vec;
    logic       fin;
  } sb_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sbq[$];
  bit   in_run = 1'b0;
  int   mvec = 0;
  run_t runs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference count, then check the cycle's result.
  task automatic cyc(input logic st, input logic v, input logic [1:0] ab,
                     input logic [6:0] flt, input logic r);
    sb_t s;
    rst = r; start = st; in_valid = v; a = ab[1]; b = ab[0];
    and_out  = (ab[1] & ab[0])    ^ flt[0];
    or_out   = (ab[1] | ab[0])    ^ flt[1];
    not_out  = (~ab[1])           ^ flt[2];
    nand_out = (~(ab[1] & ab[0])) ^ flt[3];
    nor_out  = (~(ab[1] | ab[0])) ^ flt[4];
    xor_out  = (ab[1] ^ ab[0])    ^ flt[5];
    xnor_out = (~(ab[1] ^ ab[0])) ^ flt[6];
    if (r) begin
      in_run = 1'b0; mvec = 0; sbq.delete();
    end else if (st && !in_run) begin
      in_run = 1'b1; mvec = 0;
    end else if (v && in_run) begin
      mvec++;
      sbq.push_back('{vec: 8'(mvec), fin: (mvec == 4)});
      if (mvec == 4) in_run = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      chk("sb_vec_count", 32'(vec_count), 32'(s.vec));
      chk("sb_done", 32'(done), 32'(s.fin));
      chk("sb_busy", 32'(busy), 32'(!s.fin));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_vec"}, 32'(vec_count), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_cov"}, 32'(cov), 0);
    chk({tag, "_ffv"}, 32'(first_fail_vec), 0);
    chk({tag, "_ffab"}, 32'(first_fail_ab), 0);
    chk({tag, "_ffm"}, 32'(first_fail_mask), 0);
  endtask

  task automatic do_run(input run_t r, input int idx);
    string t;
    t = $sformatf("run%0d", idx);
    cyc(1'b1, 1'b0, 2'b00, 7'd0, 1'b0);
    chk({t, "_start_busy"}, 32'(busy), 1);
    chk({t, "_start_vec"}, 32'(vec_count), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, r.ab[i], r.flt[i], 1'b0);
      if (r.gap && i < 3) cyc(1'b0, 1'b0, 2'b11, 7'h7F, 1'b0);
    end
    chk({t, "_done"}, 32'(done), 1);
    chk({t, "_vec"}, 32'(vec_count), 4);
    chk({t, "_err"}, 32'(err_count), 32'(r.exp_err));
    chk({t, "_cov"}, 32'(cov), 32'(r.exp_cov));
    chk({t, "_pass"}, 32'(pass), 32'(r.exp_pass));
    chk({t, "_ffv"}, 32'(first_fail_vec), 32'(r.exp_ffv));
    chk({t, "_ffab"}, 32'(first_fail_ab), 32'(r.exp_ffab));
    chk({t, "_ffm"}, 32'(first_fail_mask), 32'(r.exp_ffm));
    // Vectors in DONE are ignored and the verdict is held.
    cyc(1'b0, 1'b1, 2'b00, 7'h01, 1'b0);
    chk({t, "_hold_vec"}, 32'(vec_count), 4);
    chk({t, "_hold_pass"}, 32'(pass), 32'(r.exp_pass));
    chk({t, "_hold_done"}, 32'(done), 1);
  endtask

  initial begin
    //          ab (idx3..0)                    flt (idx3..0)                                          gap  err   cov      pass ffv   ffab   ffm
    runs[0] = '{'{2'b11, 2'b10, 2'b01, 2'b00}, '{7'd0, 7'd0, 7'd0, 7'd0},                           1'b0, 8'd0, 4'hF,    1'b1, 8'd0, 2'b00, 7'd0};
    runs[1] = '{'{2'b11, 2'b10, 2'b01, 2'b00}, '{7'd0, 7'b0100000, 7'd0, 7'd0},                     1'b0, 8'd1, 4'hF,    1'b0, 8'd2, 2'b10, 7'b0100000};
    runs[2] = '{'{2'b01, 2'b01, 2'b00, 2'b00}, '{7'd0, 7'd0, 7'd0, 7'd0},                           1'b0, 8'd0, 4'b0011, 1'b0, 8'd0, 2'b00, 7'd0};
    runs[3] = '{'{2'b11, 2'b10, 2'b01, 2'b00}, '{7'd0, 7'd0, 7'b0000001, 7'b0000100},               1'b0, 8'd2, 4'hF,    1'b0, 8'd0, 2'b00, 7'b0000100};
    runs[4] = '{'{2'b00, 2'b01, 2'b10, 2'b11}, '{7'd0, 7'd0, 7'd0, 7'd0},                           1'b1, 8'd0, 4'hF,    1'b1, 8'd0, 2'b00, 7'd0};
    runs[5] = '{'{2'b11, 2'b11, 2'b10, 2'b01}, '{7'b0010000, 7'd0, 7'd0, 7'd0},                     1'b0, 8'd1, 4'b1110, 1'b0, 8'd3, 2'b11, 7'b0010000};

    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b1);
    chk_zero("reset");

    for (int i = 0; i < 6; i++) do_run(runs[i], i);

    // Reset mid-run, then valid without start must not be accepted.
    cyc(1'b1, 1'b0, 2'b00, 7'd0, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 7'h04, 1'b0);
    cyc(1'b0, 1'b1, 2'b11, 7'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b1);
    chk_zero("midrst");
    cyc(1'b0, 1'b1, 2'b01, 7'd0, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 7'd0, 1'b0);
    chk_zero("noaccept");
    do_run(runs[0], 6);

    // Restart from DONE with a coincident vector, gaps, and a start pulse inside RUN.
    cyc(1'b1, 1'b1, 2'b11, 7'h20, 1'b0);
    chk("restart_done", 32'(done), 0);
    chk("restart_pass", 32'(pass), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_vec", 32'(vec_count), 0);
    chk("restart_err", 32'(err_count), 0);
    cyc(1'b0, 1'b1, 2'b00, 7'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 7'd0, 1'b0);
    chk("runstart_vec", 32'(vec_count), 1);
    chk("runstart_busy", 32'(busy), 1);
    chk("runstart_cov", 32'(cov), 32'(4'b0001));
    cyc(1'b0, 1'b1, 2'b01, 7'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 7'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    cyc(1'b0, 1'b1, 2'b11, 7'd0, 1'b0);
    chk("gaps_done", 32'(done), 1);
    chk("gaps_vec", 32'(vec_count), 4);
    chk("gaps_err", 32'(err_count), 0);
    chk("gaps_pass", 32'(pass), 1);
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
